// File: rtl/score_readout.sv
// score_readout: walks the score register file and reports best, sum, count and (with SCORE_AVERAGE_EN) average
// Ports: Clock/Reset (sync, active-high); buttonShow starts a walk from IDLE;
// registerDataP is the combinational P read data for address ReadP; busy spans the walk,
// done pulses for one cycle with bestScore/sumScore/avgScore/scoreCount valid.
// Macro SCORE_AVERAGE_EN adds a 16-cycle restoring divider producing avgScore; otherwise avgScore is 0.
module score_readout #(
  parameter int NUM_SCORES = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        buttonShow,
  input  logic [12:0] registerDataP,
  output logic [2:0]  ReadP,
  output logic        busy,
  output logic        done,
  output logic [12:0] bestScore,
  output logic [15:0] sumScore,
  output logic [12:0] avgScore,
  output logic [2:0]  scoreCount
);
  localparam logic [2:0] IDLE = 3'd0, READ_CNT = 3'd1, READ_SCORE = 3'd2, DONE = 3'd4;
  localparam logic [2:0] MAX_N = 3'(NUM_SCORES);
  logic [2:0]  state, cnt, nSat;
  logic [15:0] sumAcc, sumNext;
  logic [12:0] bestAcc, bestNext;
  assign nSat     = registerDataP[2:0] > MAX_N ? MAX_N : registerDataP[2:0];
  assign sumNext  = sumAcc + {3'b000, registerDataP};
  // strict less-than so ties keep the earlier value
  assign bestNext = registerDataP < bestAcc ? registerDataP : bestAcc;
  assign done     = state == DONE;
`ifdef SCORE_AVERAGE_EN
  localparam logic [2:0] DIVIDE = 3'd3;
  logic [15:0] quot, quotNext;
  logic [2:0]  rem, remNext;
  logic [3:0]  divCnt, trial;
  logic        fits;
  // remainder stays below N (<=7), so 3 bits hold it and the trial needs only 4
  assign trial    = {rem, quot[15]};
  assign fits     = trial >= {1'b0, cnt};
  assign remNext  = fits ? 3'(trial - {1'b0, cnt}) : trial[2:0];
  assign quotNext = {quot[14:0], fits};
  assign busy     = state == READ_CNT || state == READ_SCORE || state == DIVIDE;
`else
  assign busy     = state == READ_CNT || state == READ_SCORE;
  assign avgScore = '0;
`endif
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      ReadP      <= '0;
      cnt        <= '0;
      sumAcc     <= '0;
      bestAcc    <= 13'h1FFF;
      bestScore  <= 13'h1FFF;
      sumScore   <= '0;
      scoreCount <= '0;
`ifdef SCORE_AVERAGE_EN
      avgScore   <= '0;
      quot       <= '0;
      rem        <= '0;
      divCnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (buttonShow) begin
          state   <= READ_CNT;
          ReadP   <= '0;
          sumAcc  <= '0;
          bestAcc <= 13'h1FFF;
        end
        READ_CNT: begin
          cnt <= nSat;
          if (nSat == 3'd0) begin
            state      <= DONE;
            bestScore  <= 13'h1FFF;
            sumScore   <= '0;
            scoreCount <= '0;
`ifdef SCORE_AVERAGE_EN
            avgScore   <= '0;
`endif
          end else begin
            state <= READ_SCORE;
            ReadP <= 3'd1;
          end
        end
        READ_SCORE: begin
          sumAcc  <= sumNext;
          bestAcc <= bestNext;
          ReadP   <= ReadP + 3'd1;
          if (ReadP == cnt) begin
            ReadP <= '0;
`ifdef SCORE_AVERAGE_EN
            state  <= DIVIDE;
            quot   <= sumNext;
            rem    <= '0;
            divCnt <= '0;
`else
            state      <= DONE;
            bestScore  <= bestNext;
            sumScore   <= sumNext;
            scoreCount <= cnt;
`endif
          end
        end
`ifdef SCORE_AVERAGE_EN
        DIVIDE: begin
          quot   <= quotNext;
          rem    <= remNext;
          divCnt <= divCnt + 4'd1;
          if (divCnt == 4'd15) begin
            state      <= DONE;
            bestScore  <= bestAcc;
            sumScore   <= sumAcc;
            scoreCount <= cnt;
            avgScore   <= quotNext[12:0];
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_readout.sv
// tb_score_readout: randomized and directed checks of score_readout against an arithmetic reference model
module tb_score_readout;
  localparam int NUM = 3;
`ifdef SCORE_AVERAGE_EN
  localparam int DIV_LAT = 16;
`else
  localparam int DIV_LAT = 0;
`endif
  logic        Clock = 0, Reset = 1, buttonShow = 0;
  logic [12:0] registerDataP;
  logic [2:0]  ReadP, scoreCount;
  logic        busy, done;
  logic [12:0] bestScore, avgScore;
  logic [15:0] sumScore;
  logic [12:0] mem [8];
  int total = 0, passed = 0;

  score_readout #(.NUM_SCORES(NUM)) dut (
    .Clock(Clock), .Reset(Reset), .buttonShow(buttonShow), .registerDataP(registerDataP),
    .ReadP(ReadP), .busy(busy), .done(done), .bestScore(bestScore), .sumScore(sumScore),
    .avgScore(avgScore), .scoreCount(scoreCount)
  );

  always #5 Clock = ~Clock;
  assign registerDataP = mem[ReadP];

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int expN();
    int n = int'(mem[0][2:0]);
    return n > NUM ? NUM : n;
  endfunction

  function automatic int expLat(input int n);
    return n == 0 ? 2 : 2 + n + DIV_LAT;
  endfunction

  task automatic walk();
    int n, best, sum, avg, lat, doneAt;
    n = expN();
    best = 8191;
    sum = 0;
    for (int i = 1; i <= n; i++) begin
      sum += int'(mem[i]);
      if (int'(mem[i]) < best) best = int'(mem[i]);
    end
    avg = (DIV_LAT != 0 && n != 0) ? sum / n : 0;
    lat = expLat(n);
    @(posedge Clock); #1 buttonShow = 1;
    @(posedge Clock); #1 buttonShow = 0;
    doneAt = 0;
    for (int c = 1; c <= 40 && doneAt == 0; c++) begin
      @(negedge Clock);
      if (done) doneAt = c;
      else begin
        check("readP", ReadP, (c >= 2 && c <= 1 + n) ? c - 1 : 0);
        check("busy", busy, 1);
      end
    end
    check("doneCycle", doneAt, lat);
    check("best", bestScore, best);
    check("sum", sumScore, sum);
    check("avg", avgScore, avg);
    check("count", scoreCount, n);
    check("busyAtDone", busy, 0);
    check("readPAtDone", ReadP, 0);
    @(negedge Clock);
    check("doneOnePulse", done, 0);
  endtask

  task automatic setSlots(input int s0, input int a, input int b, input int c);
    mem[0] = 13'(s0); mem[1] = 13'(a); mem[2] = 13'(b); mem[3] = 13'(c);
  endtask

  initial begin
    int prevDone, lastDone, pulses, gapLat;
    for (int i = 0; i < 8; i++) mem[i] = 13'(100 * i + 1);
    repeat (2) @(posedge Clock);
    #1 Reset = 0;
    @(negedge Clock);
    check("rstBusy", busy, 0);
    check("rstDone", done, 0);
    check("rstReadP", ReadP, 0);
    check("rstBest", bestScore, 13'h1FFF);
    check("rstSum", sumScore, 0);
    check("rstAvg", avgScore, 0);
    check("rstCount", scoreCount, 0);

    setSlots(3, 250, 120, 400);              walk();
    setSlots(0, 11, 22, 33);                 walk();
    setSlots(13'h0FF7, 10, 20, 30);
    mem[4] = 1; mem[5] = 1; mem[6] = 1; mem[7] = 1; walk();
    setSlots(3, 8191, 8191, 5);              walk();
    setSlots(3, 7, 7, 7);                    walk();
    setSlots(2, 300, 300, 1);                walk();
    for (int r = 0; r < 10; r++) begin
      for (int i = 1; i < 8; i++) mem[i] = 13'($urandom_range(0, 8191));
      mem[0] = 13'($urandom_range(0, 8191));
      walk();
    end

    setSlots(3, 500, 600, 700);
    @(posedge Clock); #1 buttonShow = 1;
    @(posedge Clock); #1 buttonShow = 0;
    @(posedge Clock); @(posedge Clock); #1 Reset = 1;
    @(posedge Clock); #1 Reset = 0;
    @(negedge Clock);
    check("midRstBusy", busy, 0);
    check("midRstReadP", ReadP, 0);
    check("midRstBest", bestScore, 13'h1FFF);
    check("midRstSum", sumScore, 0);
    check("midRstDone", done, 0);
    repeat (3) begin
      @(negedge Clock);
      check("midRstIdle", busy | done, 0);
    end

    setSlots(1, 42, 0, 0);
    gapLat = expLat(1) + 1;
    prevDone = 0; lastDone = -1; pulses = 0;
    @(posedge Clock); #1 buttonShow = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (done) begin
        check("heldNoDouble", prevDone, 0);
        if (lastDone >= 0) check("heldGap", c - lastDone, gapLat);
        check("heldSum", sumScore, 42);
        lastDone = c;
        pulses++;
      end
      prevDone = int'(done);
    end
    #1 buttonShow = 0;
    check("heldPulses", pulses, (DIV_LAT == 0) ? 10 : 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
